// File: rtl/avalon_bus_monitor.sv
// Avalon-MM bus monitor: counts completed transfers and raises sticky range/protocol/stall/timeout faults.
// Optional feature macro MONITOR_HALT_ADDR_EN: a RUN-state read of address 0 is the CPU halt fetch.
module avalon_bus_monitor #(
   parameter logic [31:0] ADDR_BASE      = 32'hBFC00000,
   parameter int unsigned ADDR_SPAN_LOG2 = 16,
   parameter int unsigned WAIT_MAX       = 16,
   parameter int unsigned TIMEOUT_CYCLES = 100,
   parameter int unsigned CNT_W          = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             active,
   input  logic [31:0]      address,
   input  logic             read,
   input  logic             write,
   input  logic             waitrequest,
   input  logic [3:0]       byteenable,
   output logic [CNT_W-1:0] rd_count,
   output logic [CNT_W-1:0] wr_count,
   output logic [CNT_W-1:0] cycle_count,
   output logic             err_range,
   output logic             err_proto,
   output logic             err_stall,
   output logic             timeout,
   output logic             done,
   output logic [2:0]       state
);
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RUN   = 3'd1,
      STALL = 3'd2,
      DONE  = 3'd3,
      FAULT = 3'd4
   } state_t;

   localparam int unsigned      WAIT_W  = $clog2(WAIT_MAX + 2);
   localparam logic [32:0]      WIN_LO  = {1'b0, ADDR_BASE};
   localparam logic [32:0]      WIN_HI  = WIN_LO + (33'd1 << ADDR_SPAN_LOG2);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  rd_q, rd_d, wr_q, wr_d, cyc_q, cyc_d;
   logic              err_range_q, err_range_d, err_proto_q, err_proto_d;
   logic              err_stall_q, err_stall_d, timeout_q, timeout_d;
   logic [WAIT_W-1:0] wait_q, wait_d, wait_inc;
   logic [31:0]       hold_addr_q;
   logic              hold_rd_q, hold_wr_q;
   logic [3:0]        hold_be_q;

   logic busy, req, xfer_ok, halt, out_of_window, bad_shape, hold_broken;
   logic new_proto, new_range, new_stall, new_timeout, any_err;

   assign busy          = (state_q == RUN) || (state_q == STALL);
   assign req           = read | write;
   assign xfer_ok       = req & ~waitrequest;
   assign wait_inc      = wait_q + 1'b1;
   assign cyc_d         = (busy && (cyc_q != CNT_MAX)) ? cyc_q + 1'b1 : cyc_q;
   assign out_of_window = ({1'b0, address} < WIN_LO) || ({1'b0, address} >= WIN_HI);

`ifdef MONITOR_HALT_ADDR_EN
   assign halt = (state_q == RUN) && read && !write && (address == 32'h0);
`else
   assign halt = 1'b0;
`endif

   assign bad_shape = req && ((read && write) || (write && (byteenable == 4'h0)) ||
                              (address[1:0] != 2'b00));
   // A stalled transfer must hold its command unchanged (and the CPU stay active) until it completes.
   assign hold_broken = (state_q == STALL) &&
                        ((address != hold_addr_q) || (read != hold_rd_q) || (write != hold_wr_q) ||
                         (byteenable != hold_be_q) || (!active && !xfer_ok));

   assign new_proto   = busy && (bad_shape || hold_broken);
   assign new_range   = busy && req && !halt && out_of_window;
   assign new_stall   = busy && req && waitrequest && (32'(wait_inc) > WAIT_MAX);
   assign new_timeout = busy && active && (64'(cyc_d) >= 64'(TIMEOUT_CYCLES));
   assign any_err     = new_proto | new_range | new_stall | new_timeout;

   always_comb begin
      state_d     = state_q;
      rd_d        = rd_q;
      wr_d        = wr_q;
      wait_d      = wait_q;
      err_range_d = err_range_q | new_range;
      err_proto_d = err_proto_q | new_proto;
      err_stall_d = err_stall_q | new_stall;
      timeout_d   = timeout_q | new_timeout;
      unique case (state_q)
         IDLE: if (active) state_d = RUN;
         RUN, STALL: begin
            wait_d = (req && waitrequest) ? wait_inc : '0;
            if (any_err) begin
               state_d = FAULT;
            end else begin
               if (xfer_ok && !halt && read && (rd_q != CNT_MAX)) rd_d = rd_q + 1'b1;
               if (xfer_ok && write && (wr_q != CNT_MAX))         wr_d = wr_q + 1'b1;
               if (halt || !active)           state_d = DONE;
               else if (req && waitrequest)   state_d = STALL;
               else                           state_d = RUN;
            end
         end
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         rd_q        <= '0;
         wr_q        <= '0;
         cyc_q       <= '0;
         wait_q      <= '0;
         err_range_q <= 1'b0;
         err_proto_q <= 1'b0;
         err_stall_q <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         rd_q        <= rd_d;
         wr_q        <= wr_d;
         cyc_q       <= cyc_d;
         wait_q      <= wait_d;
         err_range_q <= err_range_d;
         err_proto_q <= err_proto_d;
         err_stall_q <= err_stall_d;
         timeout_q   <= timeout_d;
      end
   end

   // NOTE: the command snapshot has no reset; it is only compared in STALL, which cannot be reached
   // without first capturing a real command.
   always_ff @(posedge clk) begin
      hold_addr_q <= address;
      hold_rd_q   <= read;
      hold_wr_q   <= write;
      hold_be_q   <= byteenable;
   end

   assign rd_count    = rd_q;
   assign wr_count    = wr_q;
   assign cycle_count = cyc_q;
   assign err_range   = err_range_q;
   assign err_proto   = err_proto_q;
   assign err_stall   = err_stall_q;
   assign timeout     = timeout_q;
   assign done        = (state_q == DONE);
   assign state       = state_q;
endmodule

// File: doc/avalon_bus_monitor.md
AVALON_BUS_MONITOR -- requirements
Module: avalon_bus_monitor

Interface
REQ-001 SHALL have parameter ADDR_BASE, default 32'hBFC00000: lowest legal byte address.
REQ-002 SHALL have parameter ADDR_SPAN_LOG2, default 16: legal window is [ADDR_BASE, ADDR_BASE + 2^ADDR_SPAN_LOG2 - 1].
REQ-003 SHALL have parameter WAIT_MAX, default 16: maximum consecutive waitrequest cycles per transfer.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 100: maximum RUN cycles before timeout.
REQ-005 SHALL have parameter CNT_W, default 32: width of all counters.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 active  input  1  CPU active flag.
REQ-009 address  input  32  bus byte address.
REQ-010 read, write  input  1 each  bus requests.
REQ-011 waitrequest  input  1  slave stall.
REQ-012 byteenable  input  4  byte lanes.
REQ-013 rd_count, wr_count  output  CNT_W each  completed reads/writes.
REQ-014 cycle_count  output  CNT_W  cycles spent in RUN or STALL.
REQ-015 err_range, err_proto, err_stall, timeout  output  1 each  sticky error flags.
REQ-016 done  output  1  CPU finished cleanly.
REQ-017 state  output  3  current FSM state encoding.

Function
REQ-018 FSM states SHALL be IDLE=0, RUN=1, STALL=2, DONE=3, FAULT=4.
REQ-019 IDLE->RUN SHALL occur on the first rising edge with active=1.
REQ-020 A transfer SHALL complete on any edge with (read|write)=1 and waitrequest=0, in RUN or STALL.
REQ-021 A completed read SHALL increment rd_count and a completed write wr_count, visible the next cycle; counters SHALL saturate at all-ones.
REQ-022 RUN->STALL SHALL occur when (read|write)=1 and waitrequest=1; STALL->RUN on completion.
REQ-023 In STALL, address, read, write and byteenable changing before completion SHALL set err_proto.
REQ-024 read=1 and write=1 together, write with byteenable=0, or address[1:0]!=0 SHALL set err_proto.
REQ-025 Any request whose address lies outside the legal window SHALL set err_range, evaluated with 33-bit arithmetic so ADDR_BASE + span never wraps.
REQ-026 More than WAIT_MAX consecutive STALL cycles SHALL set err_stall.
REQ-027 cycle_count reaching TIMEOUT_CYCLES while active=1 SHALL set timeout.
REQ-028 Any error flag set SHALL move the FSM to FAULT on the same edge; FAULT SHALL be held until reset.
REQ-029 active falling in RUN SHALL move to DONE and assert done; a fall in STALL SHALL set err_proto and go to FAULT.
REQ-030 Simultaneous completion and active fall SHALL count the transfer, then enter DONE.
REQ-031 DONE and FAULT SHALL freeze all counters; error flags SHALL remain sticky.
REQ-032 Requests in IDLE SHALL be ignored (no count, no error).

Reset
REQ-033 reset=0 SHALL immediately force state=IDLE, all counters 0, all flags and done 0, independent of clk.
REQ-034 Reset asserted mid-transfer SHALL discard the transfer without counting it.

Configuration
REQ-035 With MONITOR_HALT_ADDR_EN defined, a read of address 32'h0 in RUN SHALL be treated as the CPU halt fetch: no err_range, rd_count not incremented, done asserted and FSM to DONE the next cycle.
REQ-036 Without MONITOR_HALT_ADDR_EN, address 32'h0 SHALL be checked as any other address, which sets err_range at the default ADDR_BASE.

Verification
REQ-037 active=1, 3 reads at 0xBFC00000/4/8 with waitrequest=0, then active=0 -> rd_count=3, wr_count=0, done=1, state=3.
REQ-038 Write to 0xBFC10000 -> err_range=1, state=4 next cycle, counters frozen.
REQ-039 Read held with waitrequest=1 for 17 cycles (WAIT_MAX=16) -> err_stall=1 on the 17th cycle, state=4.
REQ-040 Address changes from 0xBFC00004 to 0xBFC00008 during STALL -> err_proto=1.
REQ-041 active held 100 cycles, TIMEOUT_CYCLES=100 -> timeout=1, cycle_count=100.
REQ-042 MONITOR_HALT_ADDR_EN defined, read of 0x0 -> err_range=0, done=1; undefined -> err_range=1.
